// File: rtl/lift_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// lift_pkg
// Shared definitions for the lift car-motion scheduler.
//   - lift_state_e  : scheduler FSM states (IDLE, UP, DOWN, DOOR)
//   - MAX_FLOORS    : largest supported building (16 floors)
//   - floor_masks() : per-floor "above" / "below" bit masks used to test the
//                     pending-call vector for calls on either side of the car
// -----------------------------------------------------------------------------
package lift_pkg;

  localparam int MAX_FLOORS = 16;
  localparam int MAX_FW     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    DOOR = 2'd3
  } lift_state_e;

  typedef struct packed {
    logic [MAX_FLOORS-1:0] above;
    logic [MAX_FLOORS-1:0] below;
  } floor_masks_t;

  // Bit i of .above is set for every floor strictly higher than 'floor',
  // bit i of .below for every floor strictly lower. The caller trims the
  // masks to the real floor count.
  function automatic floor_masks_t floor_masks(input logic [MAX_FW-1:0] floor);
    floor_masks_t m;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      m.above[i] = (i > int'(floor));
      m.below[i] = (i < int'(floor));
    end
    return m;
  endfunction

endpackage

// File: rtl/lift_scheduler_if.sv
// -----------------------------------------------------------------------------
// lift_scheduler_if
// Signal bundle between the lift scheduler and its surroundings.
//   call_req  : floor call buttons, one bit per floor (requester -> scheduler)
//   cur_floor : current car floor
//   dir_up    : 1 = current or last travel direction is up
//   moving    : car travelling (UP or DOWN)
//   door_open : door open (DOOR)
//   pending   : latched, not yet serviced calls
//   state_dbg : scheduler FSM state, for observation only
//
// Handshake: call_req has no ready/acknowledge. Any cycle in which a bit is
// high counts as a request for that floor; a one-cycle pulse is enough. The
// request is acknowledged by its bit appearing in 'pending' on the next edge
// and is considered served when that bit clears as the door opens there.
// -----------------------------------------------------------------------------
interface lift_scheduler_if #(
  parameter int FLOORS = 8,
  parameter int FW     = (FLOORS > 1) ? $clog2(FLOORS) : 1
);
  import lift_pkg::*;

  logic [FLOORS-1:0] call_req;
  logic [FW-1:0]     cur_floor;
  logic              dir_up;
  logic              moving;
  logic              door_open;
  logic [FLOORS-1:0] pending;
  lift_state_e       state_dbg;

  // master: the side issuing calls and consuming car status
  modport master (
    output call_req,
    input  cur_floor, dir_up, moving, door_open, pending, state_dbg
  );

  // slave: the scheduler itself
  modport slave (
    input  call_req,
    output cur_floor, dir_up, moving, door_open, pending, state_dbg
  );

endinterface

// File: rtl/lift_scheduler_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Seconds prescaler. Counts 0..TICK_DIV-1 on the system clock and raises a
// one-cycle enable when the count sits at TICK_DIV-1. A synchronous clear
// restarts the count so the owner can make every dwell start on a fresh
// tick boundary.
//   clk_i  : system clock
//   rst_i  : synchronous active-high reset
//   clr_i  : synchronous count clear
//   tick_o : one-cycle tick enable
// -----------------------------------------------------------------------------
module tick_gen #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int             CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/lift_scheduler.sv
// -----------------------------------------------------------------------------
// lift_scheduler
// Collective (SCAN) car-motion scheduler. Latches floor calls, keeps moving in
// the current direction while calls remain ahead, stops at every called floor
// on the way, and times travel and door dwell in seconds ticks from tick_gen.
//   clk_100MHz : system clock, all logic on posedge
//   rst        : synchronous active-high reset
//   bus        : lift_scheduler_if.slave (call_req in; cur_floor, dir_up,
//                moving, door_open, pending, state_dbg out)
// Parameters: FLOORS (2..16), TICK_DIV (cycles per tick), MOVE_TICKS (ticks
// per floor), DOOR_TICKS (ticks the door stays open).
// -----------------------------------------------------------------------------
module lift_scheduler
  import lift_pkg::*;
#(
  parameter int FLOORS     = 8,
  parameter int TICK_DIV   = 100000000,
  parameter int MOVE_TICKS = 2,
  parameter int DOOR_TICKS = 3
) (
  input  logic             clk_100MHz,
  input  logic             rst,
  lift_scheduler_if.slave  bus
);

  localparam int FW   = (FLOORS > 1) ? $clog2(FLOORS) : 1;
  localparam int MAXT = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
  localparam int DW   = $clog2(MAXT + 1);

  localparam logic [DW-1:0] MOVE_LAST = DW'(MOVE_TICKS - 1);
  localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_TICKS - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  lift_state_e       state_q,   state_d;
  logic [FW-1:0]     floor_q,   floor_d;
  logic              dir_q,     dir_d;
  logic [FLOORS-1:0] pending_q, pending_d;
  logic [DW-1:0]     dwell_q,   dwell_d;
  logic              moving_q;
  logic              door_q;

  logic              tick;
  logic              cnt_clr;
  logic              step;
  logic              restart;
  logic              enter_door;
  logic [FLOORS-1:0] clr_mask;

  // ---------------------------------------------------------------------------
  // Call position helpers, from the registered pending vector, both at the
  // current floor and at the floor the car would reach on its next step.
  // ---------------------------------------------------------------------------
  logic [FW-1:0] step_floor;
  floor_masks_t  m_cur;
  floor_masks_t  m_step;
  logic          above_cur,  below_cur,  here_cur;
  logic          above_step, below_step, here_step;

  // Only consumed while in UP/DOWN, where the guards keep it inside 0..FLOORS-1.
  assign step_floor = (state_q == DOWN) ? (floor_q - FW'(1)) : (floor_q + FW'(1));

  assign m_cur  = floor_masks(MAX_FW'(floor_q));
  assign m_step = floor_masks(MAX_FW'(step_floor));

  assign above_cur  = |(pending_q & m_cur.above[FLOORS-1:0]);
  assign below_cur  = |(pending_q & m_cur.below[FLOORS-1:0]);
  assign here_cur   = pending_q[floor_q];
  assign above_step = |(pending_q & m_step.above[FLOORS-1:0]);
  assign below_step = |(pending_q & m_step.below[FLOORS-1:0]);
  assign here_step  = pending_q[step_floor];

  // ---------------------------------------------------------------------------
  // Seconds timebase
  // ---------------------------------------------------------------------------
  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk_i  (clk_100MHz),
    .rst_i  (rst),
    .clr_i  (cnt_clr),
    .tick_o (tick)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    step    = 1'b0;
    restart = 1'b0;

    case (state_q)
      IDLE: begin
        if (here_cur) begin
          state_d = DOOR;
        end else if (above_cur && below_cur) begin
          // Calls on both sides: keep the remembered direction.
          state_d = dir_q ? UP : DOWN;
        end else if (above_cur) begin
          state_d = UP;
          dir_d   = 1'b1;
        end else if (below_cur) begin
          state_d = DOWN;
          dir_d   = 1'b0;
        end
      end

      UP, DOWN: begin
        if (tick && (dwell_q == MOVE_LAST)) begin
          step    = 1'b1;
          floor_d = step_floor;
          if (here_step) begin
            state_d = DOOR;
          end else if ((state_q == UP) ? above_step : below_step) begin
            state_d = state_q;
          end else if ((state_q == UP) ? below_step : above_step) begin
            state_d = (state_q == UP) ? DOWN : UP;
            dir_d   = (state_q == DOWN);
          end else begin
            state_d = IDLE;
          end
        end
      end

      DOOR: begin
        if (bus.call_req[floor_q]) begin
          // Someone pressed this floor again: hold the door for a full dwell.
          restart = 1'b1;
        end else if (tick && (dwell_q == DOOR_LAST)) begin
          if (dir_q ? above_cur : below_cur) begin
            state_d = dir_q ? UP : DOWN;
          end else if (dir_q ? below_cur : above_cur) begin
            state_d = dir_q ? DOWN : UP;
            dir_d   = ~dir_q;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Every state change, floor step or door restart begins a fresh dwell, so
  // both the prescaler and the tick count restart together.
  assign cnt_clr = (state_d != state_q) || step || restart;

  always_comb begin
    dwell_d = dwell_q;
    if (cnt_clr) begin
      dwell_d = '0;
    end else if (tick && (state_q != IDLE)) begin
      dwell_d = dwell_q + DW'(1);
    end
  end

  // The call at the floor being served is cleared as the door opens and on
  // every re-press while it is open; a press coinciding with its clear is
  // dropped because that floor is being served right now.
  assign enter_door = (state_d == DOOR) && ((state_q != DOOR) || restart);

  always_comb begin
    clr_mask = '0;
    if (enter_door) begin
      clr_mask = FLOORS'(1) << floor_d;
    end
  end

  assign pending_d = (pending_q | bus.call_req) & ~clr_mask;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state_q   <= IDLE;
      floor_q   <= '0;
      dir_q     <= 1'b1;
      pending_q <= '0;
      dwell_q   <= '0;
      moving_q  <= 1'b0;
      door_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_q     <= dir_d;
      pending_q <= pending_d;
      dwell_q   <= dwell_d;
      moving_q  <= (state_d == UP) || (state_d == DOWN);
      door_q    <= (state_d == DOOR);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.cur_floor = floor_q;
  assign bus.dir_up    = dir_q;
  assign bus.moving    = moving_q;
  assign bus.door_open = door_q;
  assign bus.pending   = pending_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_lift_scheduler.sv
// -----------------------------------------------------------------------------
// tb_lift_scheduler
// Directed bench for lift_scheduler with FLOORS=8, TICK_DIV=4, MOVE_TICKS=2,
// DOOR_TICKS=3 (one floor = 8 cycles, door = 12 cycles). Expected door stops
// are queued in service order when calls are driven and popped whenever the
// door opens.
// -----------------------------------------------------------------------------
module tb_lift_scheduler;
  import lift_pkg::*;

  localparam int FLOORS     = 8;
  localparam int FW         = 3;
  localparam int TICK_DIV   = 4;
  localparam int MOVE_TICKS = 2;
  localparam int DOOR_TICKS = 3;
  localparam int MOVE_CYC   = MOVE_TICKS * TICK_DIV;
  localparam int DOOR_CYC   = DOOR_TICKS * TICK_DIV;

  logic clk_100MHz;
  logic rst;

  int checks = 0;
  int errors = 0;

  logic [FW-1:0] exp_q[$];

  lift_scheduler_if #(.FLOORS(FLOORS)) bus ();

  lift_scheduler #(
    .FLOORS     (FLOORS),
    .TICK_DIV   (TICK_DIV),
    .MOVE_TICKS (MOVE_TICKS),
    .DOOR_TICKS (DOOR_TICKS)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .bus        (bus.slave)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial begin
    clk_100MHz = 1'b0;
    forever #5 clk_100MHz = ~clk_100MHz;
  end

  // ---------------------------------------------------------------------------
  // Driver / checker tasks
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [FLOORS-1:0] m);
    bus.call_req = m;
    cyc();
    bus.call_req = '0;
  endtask

  task automatic wait_floor(input int f, input int budget);
    int n;
    n = 0;
    while ((int'(bus.cur_floor) != f) && (n < budget)) begin
      cyc();
      n++;
    end
    chk("wait_floor", 32'(bus.cur_floor), 32'(f));
  endtask

  // Wait for the door, then pop the scoreboard and compare the stop floor.
  task automatic wait_door(input int budget);
    int n;
    n = 0;
    while ((bus.door_open !== 1'b1) && (n < budget)) begin
      cyc();
      n++;
    end
    chk("door_reached", 32'(bus.door_open), 32'd1);
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL sb_unexpected_stop: observed door at floor %0d expected no stop", bus.cur_floor);
    end
    if (exp_q.size() != 0) begin
      chk("door_floor", 32'(bus.cur_floor), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic door_len(input string tag);
    int n;
    n = 0;
    while ((bus.door_open === 1'b1) && (n < 100)) begin
      cyc();
      n++;
    end
    chk(tag, 32'(n), 32'(DOOR_CYC));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_floor"},   32'(bus.cur_floor), 32'd0);
    chk({tag, "_dir"},     32'(bus.dir_up),    32'd1);
    chk({tag, "_moving"},  32'(bus.moving),    32'd0);
    chk({tag, "_door"},    32'(bus.door_open), 32'd0);
    chk({tag, "_pending"}, 32'(bus.pending),   32'd0);
    chk({tag, "_state"},   32'(bus.state_dbg), 32'(IDLE));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // Reset with calls pressed: they must not latch.
    rst          = 1'b1;
    bus.call_req = '1;
    repeat (3) cyc();
    chk_reset_outputs("rst");
    bus.call_req = '0;
    rst          = 1'b0;
    cyc();
    chk("post_rst_pending", 32'(bus.pending), 32'd0);

    // Call at the floor the car is parked on.
    exp_q.push_back(3'd0);
    pulse(8'h01);
    chk("f0_pending_set", 32'(bus.pending), 32'h01);
    chk("f0_door_early",  32'(bus.door_open), 32'd0);
    cyc();
    chk("f0_door_open",   32'(bus.door_open), 32'd1);
    chk("f0_pending_clr", 32'(bus.pending),   32'd0);
    wait_door(2);
    door_len("f0_door_len");
    chk("f0_idle", 32'(bus.state_dbg), 32'(IDLE));

    // Trip 0 -> 3, checking each floor step lands exactly every MOVE_CYC.
    exp_q.push_back(3'd3);
    pulse(8'h08);
    chk("up3_pending",     32'(bus.pending), 32'h08);
    chk("up3_move_early",  32'(bus.moving),  32'd0);
    cyc();
    chk("up3_moving",      32'(bus.moving),    32'd1);
    chk("up3_dir",         32'(bus.dir_up),    32'd1);
    chk("up3_start_floor", 32'(bus.cur_floor), 32'd0);
    for (int f = 1; f <= 3; f++) begin
      repeat (MOVE_CYC - 1) cyc();
      chk("up3_floor_hold", 32'(bus.cur_floor), 32'(f - 1));
      cyc();
      chk("up3_floor_step", 32'(bus.cur_floor), 32'(f));
    end
    chk("up3_door",       32'(bus.door_open), 32'd1);
    chk("up3_stopped",    32'(bus.moving),    32'd0);
    chk("up3_pending_clr", 32'(bus.pending),  32'd0);
    wait_door(2);
    door_len("up3_door_len");
    chk("up3_idle", 32'(bus.state_dbg), 32'(IDLE));

    // Re-press the open floor on the 10th door cycle: full dwell from the press.
    exp_q.push_back(3'd3);
    pulse(8'h08);
    cyc();
    wait_door(2);
    repeat (9) cyc();
    bus.call_req = 8'h08;
    cyc();
    bus.call_req = '0;
    chk("repress_door",    32'(bus.door_open), 32'd1);
    chk("repress_pending", 32'(bus.pending),   32'd0);
    door_len("repress_door_len");

    // Plain reset back to floor 0.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_reset_outputs("rst2");

    // Collective run: call 5, then 1 and 4 while passing floor 2.
    exp_q.push_back(3'd5);
    pulse(8'h20);
    wait_floor(2, 100);
    repeat (2) cyc();
    chk("scan_moving_up", 32'(bus.moving), 32'd1);
    // Service order: 4 on the way up, before the queued 5; 1 after reversing.
    exp_q.push_front(3'd4);
    exp_q.push_back(3'd1);
    pulse(8'h12);
    wait_door(100);
    chk("scan_dir_at4", 32'(bus.dir_up), 32'd1);
    door_len("scan_door4_len");
    wait_door(100);
    chk("scan_dir_at5", 32'(bus.dir_up), 32'd1);
    door_len("scan_door5_len");
    chk("scan_dir_flip",   32'(bus.dir_up), 32'd0);
    chk("scan_moving_dn",  32'(bus.moving), 32'd1);
    wait_door(100);
    door_len("scan_door1_len");
    chk("scan_idle",    32'(bus.state_dbg), 32'(IDLE));
    chk("scan_pending", 32'(bus.pending),   32'd0);

    // Reset mid-travel between floors 4 and 5 with a call outstanding.
    exp_q.push_back(3'd7);
    pulse(8'h80);
    wait_floor(4, 100);
    repeat (3) cyc();
    chk("midrst_moving", 32'(bus.moving), 32'd1);
    rst          = 1'b1;
    bus.call_req = 8'h04;
    cyc();
    chk_reset_outputs("midrst");
    rst          = 1'b0;
    bus.call_req = '0;
    exp_q.delete();
    cyc();
    chk("midrst_pending", 32'(bus.pending), 32'd0);
    chk("midrst_still",   32'(bus.moving),  32'd0);

    // First call after reset is served from floor 0.
    exp_q.push_back(3'd2);
    pulse(8'h04);
    cyc();
    chk("after_rst_moving", 32'(bus.moving),    32'd1);
    chk("after_rst_floor",  32'(bus.cur_floor), 32'd0);
    wait_door(100);
    door_len("after_rst_door_len");
    chk("after_rst_idle", 32'(bus.state_dbg), 32'(IDLE));

    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lift_scheduler.md
# lift_scheduler

Car-motion scheduler for the lift controller: latches floor call requests, chooses travel direction with a collective (SCAN) policy, times floor-to-floor travel and door dwell from an internal 1 s tick, and drives the car-position and door outputs consumed by the display and indicator logic. It runs entirely on the 100 MHz system clock; the seconds timebase is a one-cycle clock-enable, never a derived clock.

## Interface
- FLOORS, 8: number of floors, 2..16; floor 0 is the bottom.
- TICK_DIV, 100000000: system cycles per tick (1 s at 100 MHz).
- MOVE_TICKS, 2: ticks to travel one floor.
- DOOR_TICKS, 3: ticks the door stays open.
- clk_100MHz  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- call_req  in  FLOORS  call buttons, one bit per floor; a 1-cycle pulse is sufficient.
- cur_floor  out  FW = $clog2(FLOORS)  current car floor.
- dir_up  out  1  1 = current or last direction up.
- moving  out  1  high in UP and DOWN.
- door_open  out  1  high in DOOR.
- pending  out  FLOORS  latched unserviced calls.

## Operation
- pending: each cycle, pending <= (pending | call_req) & ~clr. clr is the one-hot of cur_floor in the cycle the FSM enters DOOR, or in any DOOR cycle where call_req[cur_floor] is high. A call that arrives together with its own clear is dropped (it is being serviced).
- Helpers, from registered pending: above = any bit > cur_floor; below = any bit < cur_floor; here = pending[cur_floor].
- States: IDLE, UP, DOWN, DOOR.
- IDLE: here -> DOOR. Otherwise, if above and below are both set, continue in the dir_up direction. Otherwise above -> UP with dir_up=1, below -> DOWN with dir_up=0. No pending calls -> stay in IDLE.
- UP/DOWN: after MOVE_TICKS ticks in the state, cur_floor steps ±1 and the tick count restarts. Then, in the same edge:
  - here at the new floor -> DOOR.
  - else a call further in the current direction -> stay.
  - else a call in the opposite direction -> switch to the other move state, flipping dir_up.
  - else IDLE.
- DOOR: call_req[cur_floor] restarts the dwell count. After DOOR_TICKS ticks: a call in the dir_up direction -> that move state; else a call in the opposite direction -> the other move state, flipping dir_up; else IDLE.
- Guards: cur_floor never leaves 0..FLOORS-1. UP is never entered at FLOORS-1 and DOWN is never entered at 0, because above and below are empty there.
- Reset, including mid-move or with the door open:
  - state=IDLE, cur_floor=0, dir_up=1, moving=0, door_open=0, pending=0.
  - Prescaler and dwell counters are cleared.
  - call_req is ignored during reset cycles.

## Timing
- Prescaler: counts 0..TICK_DIV-1 and emits tick when count==TICK_DIV-1. It clears on every state change and every floor step, so each dwell is exact: move = MOVE_TICKS*TICK_DIV cycles, door = DOOR_TICKS*TICK_DIV cycles.
- Request latency: call_req sampled at edge k sets pending after k. The FSM acts at edge k+1, so door_open or moving rises 2 edges after the sampled request.
- Outputs are registered. moving, door_open and cur_floor change on the same edge as the state.
- Counter widths: prescaler $clog2(TICK_DIV); dwell counter $clog2(max(MOVE_TICKS,DOOR_TICKS)+1).

## Structure
- Package lift_pkg holds:
  - the state enum (IDLE, UP, DOWN, DOOR);
  - MAX_FLOORS=16;
  - a function returning the above/below masks for a floor index.
- Sub-module tick_gen: prescaler with synchronous clear, parameter TICK_DIV, output a 1-cycle tick enable. It replaces toggled divided clocks for all seconds-based timing.
- Top level holds the FSM, the pending register and the dwell counter.

## Test plan
Bench parameters: FLOORS=8, TICK_DIV=4, MOVE_TICKS=2, DOOR_TICKS=3 (move = 8 cycles, door = 12 cycles).
- Reset -> cur_floor=0, dir_up=1, moving=0, door_open=0, pending=0. Pulse call_req during rst -> pending stays 0.
- Idle at floor 0, pulse call_req[0] -> door_open high 2 edges later for exactly 12 cycles, pending[0] cleared, then IDLE.
- Idle at floor 0, pulse call_req[3] -> moving high 2 edges later. cur_floor steps 1,2,3 at 8-cycle intervals. At floor 3: door_open for 12 cycles, then IDLE.
- Moving up past floor 2 with pending[5] set, pulse call_req[1] and call_req[4]:
  - stop at 4 (door) and at 5 (door);
  - dir_up then flips to 0;
  - descend to 1 with no stop at 2 or 3.
- Door open at floor 3, pulse call_req[3] on the 10th door cycle -> door stays open 12 cycles from the pulse, pending[3] stays 0.
- Assert rst mid-travel between floors 4 and 5 with calls pending -> all outputs return to reset values on the next edge. The first new call is serviced from floor 0.
